// File: rtl/ppm_tx_pkg.sv
// ============================================================================
// ppm_tx_pkg : shared line levels, default marker patterns and FSM state type
// Revision   : 1.0
// ============================================================================
`default_nettype none

package ppm_tx_pkg;

    localparam logic LVL_IDLE = 1'b1;
    localparam logic LVL_MARK = 1'b0;

    // Slot i of a marker is bit i (LSB first); the decoder matches the same words.
    localparam logic [7:0] SOF_PATTERN_DEFAULT = 8'b1101_1110;
    localparam logic [7:0] EOF_PATTERN_DEFAULT = 8'b0111_1011;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } marker_state_t;

endpackage

`default_nettype wire

// File: rtl/slot_timer.sv
// ============================================================================
// slot_timer : clocks-per-slot and slot-index counters with last-slot flags
// Revision   : 1.0
// ============================================================================
`default_nettype none

module slot_timer #(
    parameter int SLOT_CLKS = 16,
    parameter int NUM_SLOTS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         clr,
    output logic [$clog2(NUM_SLOTS)-1:0] slot_idx,
    output logic                         slot_last,
    output logic                         marker_last
);

    localparam int CW = $clog2(SLOT_CLKS);
    localparam int SW = $clog2(NUM_SLOTS);

    logic [CW-1:0] clk_cnt;

    assign slot_last   = (clk_cnt == CW'(SLOT_CLKS - 1));
    assign marker_last = slot_last && (slot_idx == SW'(NUM_SLOTS - 1));

    // Both counters wrap explicitly so non-power-of-two sizes never leave range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt  <= '0;
            slot_idx <= '0;
        end else if (clr) begin
            clk_cnt  <= '0;
            slot_idx <= '0;
        end else if (en) begin
            if (slot_last) begin
                clk_cnt  <= '0;
                slot_idx <= marker_last ? '0 : slot_idx + SW'(1);
            end else begin
                clk_cnt  <= clk_cnt + CW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ppm_marker_gen.sv
// ============================================================================
// ppm_marker_gen : SOF/EOF marker waveform generator with start/busy/done/abort
// Optional macro PPM_MARKER_REPEAT_EN adds rep_cnt back-to-back repetitions.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module ppm_marker_gen
    import ppm_tx_pkg::*;
#(
    parameter int                   SLOT_CLKS   = 16,
    parameter int                   NUM_SLOTS   = 8,
    parameter logic [NUM_SLOTS-1:0] SOF_PATTERN = SOF_PATTERN_DEFAULT,
    parameter logic [NUM_SLOTS-1:0] EOF_PATTERN = EOF_PATTERN_DEFAULT,
    parameter logic                 IDLE_LEVEL  = LVL_IDLE
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef PPM_MARKER_REPEAT_EN
    input  logic [3:0] rep_cnt,
`endif
    input  logic       start,
    input  logic       sel_eof,
    input  logic       abort,
    output logic       marker,
    output logic       busy,
    output logic       done
);

    localparam int SW = $clog2(NUM_SLOTS);

    marker_state_t        state;
    logic                 pat_sel;
    logic [SW-1:0]        slot_idx;
    logic                 slot_last;
    logic                 marker_last;
    logic [SW-1:0]        w_slot_nxt;
    logic [NUM_SLOTS-1:0] w_pattern;
    logic                 w_more_reps;

`ifdef PPM_MARKER_REPEAT_EN
    logic [3:0] rep_left;
    assign w_more_reps = (rep_left != 4'd0);
`else
    assign w_more_reps = 1'b0;
`endif

    assign w_pattern = pat_sel ? EOF_PATTERN : SOF_PATTERN;

    // Output is registered, so it must show the level of the slot the timer moves into.
    assign w_slot_nxt = !slot_last  ? slot_idx :
                        marker_last ? '0 : slot_idx + SW'(1);

    slot_timer #(
        .SLOT_CLKS (SLOT_CLKS),
        .NUM_SLOTS (NUM_SLOTS)
    ) u_slot_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (state == EMIT),
        .clr         (abort),
        .slot_idx    (slot_idx),
        .slot_last   (slot_last),
        .marker_last (marker_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pat_sel <= 1'b0;
            marker  <= IDLE_LEVEL;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef PPM_MARKER_REPEAT_EN
            rep_left <= 4'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state   <= EMIT;
                        pat_sel <= sel_eof;
                        marker  <= sel_eof ? EOF_PATTERN[0] : SOF_PATTERN[0];
                        busy    <= 1'b1;
`ifdef PPM_MARKER_REPEAT_EN
                        rep_left <= rep_cnt;
`endif
                    end
                end
                EMIT: begin
                    if (abort) begin
                        state  <= IDLE;
                        marker <= IDLE_LEVEL;
                        busy   <= 1'b0;
`ifdef PPM_MARKER_REPEAT_EN
                        rep_left <= 4'd0;
`endif
                    end else if (marker_last && !w_more_reps) begin
                        state  <= IDLE;
                        marker <= IDLE_LEVEL;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        marker <= w_pattern[w_slot_nxt];
`ifdef PPM_MARKER_REPEAT_EN
                        if (marker_last) begin
                            rep_left <= rep_left - 4'd1;
                        end
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ppm_marker_gen.sv
// ============================================================================
// tb_ppm_marker_gen : bench for ppm_marker_gen, default and 5x3 configurations
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_ppm_marker_gen;

    localparam logic [7:0] SOF_A = 8'b1101_1110;
    localparam logic [7:0] EOF_A = 8'b0111_1011;
    localparam logic [7:0] SOF_B = 8'b0000_0010;
    localparam logic [7:0] EOF_B = 8'b0000_0101;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, sel_eof, abort;
    logic [3:0] rep_cnt;
    logic       marker_a, busy_a, done_a;
    logic       marker_b, busy_b, done_b;

    always #5 clk = ~clk;

    ppm_marker_gen u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef PPM_MARKER_REPEAT_EN
        .rep_cnt (rep_cnt),
`endif
        .start   (start),
        .sel_eof (sel_eof),
        .abort   (abort),
        .marker  (marker_a),
        .busy    (busy_a),
        .done    (done_a)
    );

    ppm_marker_gen #(
        .SLOT_CLKS   (5),
        .NUM_SLOTS   (3),
        .SOF_PATTERN (3'b010),
        .EOF_PATTERN (3'b101)
    ) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef PPM_MARKER_REPEAT_EN
        .rep_cnt (rep_cnt),
`endif
        .start   (start),
        .sel_eof (sel_eof),
        .abort   (abort),
        .marker  (marker_b),
        .busy    (busy_b),
        .done    (done_b)
    );

    // Reference: a marker is an elapsed-cycle count over a fixed length.
    typedef struct {
        bit       active;
        int       t;
        int       len;
        bit [7:0] pat;
        bit       marker;
        bit       busy;
        bit       done;
    } mdl_t;

    mdl_t ma, mb;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.active = 0; m.t = 0; m.len = 0; m.pat = '0;
        m.marker = 1'b1; m.busy = 0; m.done = 0;
        return m;
    endfunction

    function automatic mdl_t step(mdl_t m, int s, int n, bit [7:0] sof, bit [7:0] eof,
                                  bit st, bit sel, bit ab, int rep);
        mdl_t r;
        r = m;
        r.done = 0;
        if (m.active) begin
            if (ab) r.active = 0;
            else begin
                r.t = m.t + 1;
                if (r.t == m.len) begin
                    r.active = 0;
                    r.done   = 1;
                end
            end
        end else if (st && !ab) begin
            r.active = 1;
            r.t      = 0;
            r.len    = s * n * (rep + 1);
            r.pat    = sel ? eof : sof;
        end
        r.busy   = r.active;
        r.marker = r.active ? r.pat[(r.t / s) % n] : 1'b1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit st, input bit sel, input bit ab, input int rep);
        start   = st;
        sel_eof = sel;
        abort   = ab;
        rep_cnt = 4'(rep);
        @(posedge clk);
        #1;
        ma = step(ma, 16, 8, SOF_A, EOF_A, st, sel, ab, rep);
        mb = step(mb, 5, 3, SOF_B, EOF_B, st, sel, ab, rep);
        chk("a_marker", marker_a, ma.marker);
        chk("a_busy",   busy_a,   ma.busy);
        chk("a_done",   done_a,   ma.done);
        chk("b_marker", marker_b, mb.marker);
        chk("b_busy",   busy_b,   mb.busy);
        chk("b_done",   done_b,   mb.done);
    endtask

    typedef struct {
        bit sel;
        bit abort_with_start;
        int abort_at;
        int extra_at;
        int exp_low_a;
        int exp_busy_a;
        int exp_done_a;
        int exp_busy_b;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int lows, ba, bb, da, d, rep_max;

        vecs[0] = '{0, 0, -1, -1, 32, 128, 128, 15};
        vecs[1] = '{1, 0, -1, 40, 32, 128, 128, 30};
        vecs[2] = '{0, 0, 30, 35, 48, 158, 163, 30};
        vecs[3] = '{0, 1, -1, -1,  0,   0,  -1,  0};

        rst_n = 1'b0; start = 0; sel_eof = 0; abort = 0; rep_cnt = 0;
        ma = mdl_reset();
        mb = mdl_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_marker", marker_a, 1); chk("rst_a_busy", busy_a, 0); chk("rst_a_done", done_a, 0);
        chk("rst_b_marker", marker_b, 1); chk("rst_b_busy", busy_b, 0); chk("rst_b_done", done_b, 0);
        rst_n = 1'b1;

        repeat (50) cycle(0, $urandom_range(0, 1), 0, 0);

        foreach (vecs[v]) begin
            lows = 0; ba = 0; bb = 0; da = -1;
            for (int c = 0; c < 200; c++) begin
                cycle((c == 0) || (c == vecs[v].extra_at),
                      (c == 0) ? vecs[v].sel : 1'($urandom_range(0, 1)),
                      (c == vecs[v].abort_at) || (c == 0 && vecs[v].abort_with_start), 0);
                if (marker_a === 1'b0) lows++;
                if (busy_a === 1'b1) ba++;
                if (busy_b === 1'b1) bb++;
                if (done_a === 1'b1) da = c;
            end
            chk("vec_low_a",  lows, vecs[v].exp_low_a);
            chk("vec_busy_a", ba,   vecs[v].exp_busy_a);
            chk("vec_done_a", da,   vecs[v].exp_done_a);
            chk("vec_busy_b", bb,   vecs[v].exp_busy_b);
        end

        // Start in the cycle after done: one idle cycle between markers.
        cycle(1, 0, 0, 0);
        d = -1;
        for (int c = 0; c < 300 && d < 0; c++) begin
            cycle(0, 0, 0, 0);
            if (done_a === 1'b1) d = c;
        end
        chk("b2b_done_seen", (d >= 0), 1);
        chk("b2b_gap_busy", busy_a, 0);
        chk("b2b_gap_marker", marker_a, 1);
        cycle(1, 0, 0, 0);
        chk("b2b_restart_busy", busy_a, 1);
        chk("b2b_restart_marker", marker_a, SOF_A[0]);
        repeat (140) cycle(0, 0, 0, 0);

        // Asynchronous reset mid-marker.
        cycle(1, 1, 0, 0);
        repeat (20) cycle(0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        ma = mdl_reset();
        mb = mdl_reset();
        chk("arst_marker", marker_a, 1); chk("arst_busy", busy_a, 0); chk("arst_done", done_a, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (140) cycle(0, 0, 0, 0);

`ifdef PPM_MARKER_REPEAT_EN
        rep_max = 3;
        ba = 0; da = 0; lows = 0;
        cycle(1, 0, 0, 2);
        for (int c = 0; c < 420; c++) begin
            if (busy_a === 1'b1 && da == 0) ba++;
            if (done_a === 1'b1) da++;
            cycle(0, 0, 0, 0);
        end
        chk("rep_busy_len", ba, 384);
        chk("rep_done_count", da, 1);
`else
        rep_max = 0;
`endif

        for (int c = 0; c < 4000; c++) begin
            cycle($urandom_range(0, 19) == 0, $urandom_range(0, 1),
                  $urandom_range(0, 149) == 0, $urandom_range(0, rep_max));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ppm_marker_gen.md
Name: ppm_marker_gen

Overview:
- Parametrised frame-marker generator for the PPM transmitter.
- Emits SOF or EOF marker waveforms, built from NUM_SLOTS slots of SLOT_CLKS clocks each. Each slot is driven at a per-slot level taken from a compile-time pattern.
- Sits between the transmit framing controller (start/select/abort) and the line driver mux.
- Adds a start/busy/done handshake, abort, and a second marker pattern.

Parameters:
- SLOT_CLKS, 16, clocks per slot; must be >= 2
- NUM_SLOTS, 8, slots per marker; must be >= 2
- SOF_PATTERN, 8'b1101_1110, per-slot line level for SOF; bit i = slot i, LSB first; width NUM_SLOTS
- EOF_PATTERN, 8'b0111_1011, per-slot line level for EOF; width NUM_SLOTS
- IDLE_LEVEL, 1'b1, line level when not emitting

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; accepted only when idle
- sel_eof  in  1  sampled with accepted start; 0 = SOF_PATTERN, 1 = EOF_PATTERN
- abort  in  1  synchronous cancel of a marker in progress
- marker  out  1  registered line level
- busy  out  1  high while a marker is being emitted
- done  out  1  one-cycle pulse after the last slot completes

Behaviour:
- Reset (async, rst_n low): marker = IDLE_LEVEL, busy = 0, done = 0, state IDLE, all counters 0. Reset mid-marker aborts immediately; no done is produced.
- States:
  - IDLE -> EMIT on start.
  - EMIT -> IDLE on last cycle of last slot, or on abort.
- Pattern latch: accepted start latches sel_eof into a pattern register. sel_eof is ignored at all other times.
- Timing, with start sampled high at edge k:
  - Edge k+1: marker = pattern[0], busy = 1.
  - Slot i occupies edges k+1+i*SLOT_CLKS through k+(i+1)*SLOT_CLKS.
  - Edge k+1+NUM_SLOTS*SLOT_CLKS: marker = IDLE_LEVEL, busy = 0, done = 1 for exactly one cycle.
  - Total marker length is NUM_SLOTS*SLOT_CLKS cycles.
- Counters:
  - clk_cnt has width $clog2(SLOT_CLKS); it wraps SLOT_CLKS-1 -> 0 and increments slot_idx on wrap.
  - slot_idx has width $clog2(NUM_SLOTS).
  - No counter value outside the legal range is ever reached.
- Start while busy: ignored, no queuing. This includes start in the same cycle done is asserted.
- Start in the cycle after done: accepted normally, giving back-to-back markers with exactly one IDLE_LEVEL cycle between them.
- Abort:
  - Sampled high in EMIT: next edge gives marker = IDLE_LEVEL, busy = 0, done = 0, counters cleared.
  - Abort in IDLE: no effect.
  - Abort and start high together in IDLE: abort wins, start is dropped.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: PPM_MARKER_REPEAT_EN.
- Defined:
  - Adds input rep_cnt [3:0], sampled with the accepted start.
  - The selected marker is emitted rep_cnt+1 times back-to-back, with no idle gap.
  - busy stays high throughout; done pulses once after the final repetition.
  - Abort cancels all remaining repetitions.
- Not defined: port absent; exactly one marker per start.

Decomposition:
- Package ppm_tx_pkg holds:
  - slot/level constants: LVL_IDLE, LVL_MARK
  - default SOF/EOF pattern localparams, shared with the decoder
  - state enum type marker_state_t {IDLE, EMIT}
- Sub-module slot_timer contains clk_cnt and slot_idx, and outputs slot_idx, slot_last and marker_last. It is reused by the PPM data-symbol generator.
- Top level holds the FSM, pattern register and output registers.

Test Plan:
- Reset then idle 50 clocks -> marker = 1, busy = 0, done never high.
- Default params, start with sel_eof = 0 at edge 10 -> marker low edges 11–26 and 91–106, high otherwise. busy high edges 11–138. done high at edge 139 only.
- sel_eof = 1 -> levels per EOF_PATTERN slot-by-slot. Also pulse start again at edge 50 -> ignored, waveform unchanged.
- Abort at edge 40 of a SOF started at edge 10 -> edge 41: marker = 1, busy = 0. No done pulse. A new start at edge 45 yields a full, correct marker.
- Start in the cycle after done -> second marker begins with exactly one idle cycle gap. Separately, start+abort together in IDLE -> nothing emitted.
- With PPM_MARKER_REPEAT_EN, rep_cnt = 2 -> three contiguous SOFs (384 cycles), busy continuous, a single done pulse.
- Rerun with SLOT_CLKS = 5, NUM_SLOTS = 3 -> 15-cycle marker.
